// File: rtl/dcache_refill_pkg.sv
// rtl/dcache_refill_pkg.sv - shared defaults, state encodings and beat helper for dcache_refill
// Holds the default line/bus widths, the 3-bit refill FSM state encodings,
// the default beat count and a helper that derives the beat count from widths.
package dcache_refill_pkg;

  localparam int LINE_W_DEF = 64;
  localparam int MEM_W_DEF  = 32;
  localparam int BEATS      = LINE_W_DEF / MEM_W_DEF;

  typedef enum logic [2:0] {
    RF_IDLE      = 3'd0,
    RF_WB_REQ    = 3'd1,
    RF_FILL_REQ  = 3'd2,
    RF_FILL_WAIT = 3'd3,
    RF_REFRESH   = 3'd4,
    RF_DONE      = 3'd5
  } rf_state_e;

  function automatic int rf_beats(input int line_w, input int mem_w);
    return line_w / mem_w;
  endfunction

endpackage

// File: rtl/dcache_line_buf.sv
// rtl/dcache_line_buf.sv - refill line buffer, one MEM_W slot per memory beat
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears every slot)
//   i_we         : write slot i_idx with i_wdata this cycle
//   i_idx        : slot index (beat number, slot 0 = line bits [MEM_W-1:0])
//   i_wdata      : beat data
//   o_line       : whole line, slots concatenated little-endian
module dcache_line_buf #(
  parameter int BEATS = 2,
  parameter int MEM_W = 32,
  parameter int IDX_W = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [IDX_W-1:0]         i_idx,
  input  logic [MEM_W-1:0]         i_wdata,
  output logic [BEATS*MEM_W-1:0]   o_line
);

  logic [BEATS-1:0][MEM_W-1:0] r_slots;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slots <= '0;
    end else if (i_we) begin
      r_slots[i_idx] <= i_wdata;
    end
  end

  assign o_line = r_slots;

endmodule

// File: rtl/dcache_refill.sv
// rtl/dcache_refill.sv - dcache miss service: victim write-back, beat-wise refill, tag refresh
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   i_miss, i_write_back        : miss level from the tag array, victim-dirty flag
//   i_req_addr                  : missing access address
//   i_victim_addr/i_victim_data : line-aligned victim address and contents
//   o_busy                      : pipeline stall (combinational on a fresh miss)
//   o_refresh, o_fill_we        : one-cycle install pulse, with o_fill_data as the new line
//   o_mem_req/we/addr/wdata     : registered memory beat request, held until i_mem_ready
//   i_mem_ready                 : beat accepted
//   i_mem_rvalid/i_mem_rdata    : read beat return
module dcache_refill
  import dcache_refill_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int LINE_W = LINE_W_DEF,
  parameter int MEM_W  = MEM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic              i_write_back,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [ADDR_W-1:0] i_victim_addr,
  input  logic [LINE_W-1:0] i_victim_data,
  output logic              o_busy,
  output logic              o_refresh,
  output logic              o_fill_we,
  output logic [LINE_W-1:0] o_fill_data,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [MEM_W-1:0]  o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic              i_mem_rvalid,
  input  logic [MEM_W-1:0]  i_mem_rdata
);

  localparam int N_BEATS = rf_beats(LINE_W, MEM_W);
  localparam int BW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int STEP    = MEM_W / 8;

  rf_state_e         r_state, w_state_nxt;
  logic [BW-1:0]     r_beat, w_beat_nxt;
  logic              w_last;
  logic [ADDR_W-1:0] r_line_base, r_victim_addr;
  logic [LINE_W-1:0] r_victim_data;
  logic [ADDR_W-1:0] w_req_base, w_line_base, w_victim_base, w_offset;
  logic [LINE_W-1:0] w_victim_line;
  logic              w_mem_req_nxt, w_mem_we_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [MEM_W-1:0]  w_mem_wdata_nxt;
  logic              w_buf_we;
  logic              w_unused_ok;

  assign w_req_base  = {i_req_addr[ADDR_W-1:3], 3'b000};
  assign w_unused_ok = &{1'b0, i_req_addr[2:0]};
  assign w_last      = (r_beat == BW'(N_BEATS - 1));

  // The mem_* registers load on the same edge that captures the request, so
  // while leaving IDLE the live inputs stand in for the captured copies.
  assign w_line_base   = (r_state == RF_IDLE) ? w_req_base    : r_line_base;
  assign w_victim_base = (r_state == RF_IDLE) ? i_victim_addr : r_victim_addr;
  assign w_victim_line = (r_state == RF_IDLE) ? i_victim_data : r_victim_data;
  assign w_offset      = ADDR_W'(w_beat_nxt) * ADDR_W'(STEP);

  // State and beat register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RF_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Next state and next beat
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    case (r_state)
      RF_IDLE: begin
        w_beat_nxt = '0;
        if (i_miss) w_state_nxt = i_write_back ? RF_WB_REQ : RF_FILL_REQ;
      end
      RF_WB_REQ: begin
        if (i_mem_ready) begin
          if (w_last) begin
            w_beat_nxt  = '0;
            w_state_nxt = RF_FILL_REQ;
          end else begin
            w_beat_nxt = r_beat + BW'(1);
          end
        end
      end
      RF_FILL_REQ: begin
        if (i_mem_ready) w_state_nxt = RF_FILL_WAIT;
      end
      RF_FILL_WAIT: begin
        if (i_mem_rvalid) begin
          if (w_last) begin
            w_state_nxt = RF_REFRESH;
          end else begin
            w_beat_nxt  = r_beat + BW'(1);
            w_state_nxt = RF_FILL_REQ;
          end
        end
      end
      RF_REFRESH: begin
        w_beat_nxt  = '0;
        w_state_nxt = RF_DONE;
      end
      RF_DONE:  w_state_nxt = RF_IDLE;
      default: begin
        w_state_nxt = RF_IDLE;
        w_beat_nxt  = '0;
      end
    endcase
  end

  // Outputs: combinational status plus next values of the bus registers,
  // derived from the state being entered so they are valid the cycle it starts.
  always_comb begin
    o_busy          = ((r_state != RF_IDLE) && (r_state != RF_DONE)) ||
                      ((r_state == RF_IDLE) && i_miss);
    o_refresh       = (r_state == RF_REFRESH);
    o_fill_we       = (r_state == RF_REFRESH);
    w_mem_req_nxt   = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = '0;
    w_mem_wdata_nxt = '0;
    case (w_state_nxt)
      RF_WB_REQ: begin
        w_mem_req_nxt   = 1'b1;
        w_mem_we_nxt    = 1'b1;
        w_mem_addr_nxt  = w_victim_base + w_offset;
        w_mem_wdata_nxt = w_victim_line[int'(w_beat_nxt)*MEM_W +: MEM_W];
      end
      RF_FILL_REQ: begin
        w_mem_req_nxt  = 1'b1;
        w_mem_addr_nxt = w_line_base + w_offset;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      o_mem_req   <= w_mem_req_nxt;
      o_mem_we    <= w_mem_we_nxt;
      o_mem_addr  <= w_mem_addr_nxt;
      o_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  // Request capture; frozen for the whole service
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_base   <= '0;
      r_victim_addr <= '0;
      r_victim_data <= '0;
    end else if ((r_state == RF_IDLE) && i_miss) begin
      r_line_base <= w_req_base;
      if (i_write_back) begin
        r_victim_addr <= i_victim_addr;
        r_victim_data <= i_victim_data;
      end
    end
  end

  assign w_buf_we = (r_state == RF_FILL_WAIT) && i_mem_rvalid;

  dcache_line_buf #(
    .BEATS (N_BEATS),
    .MEM_W (MEM_W),
    .IDX_W (BW)
  ) u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_buf_we),
    .i_idx   (r_beat),
    .i_wdata (i_mem_rdata),
    .o_line  (o_fill_data)
  );

endmodule

// File: tb/tb_dcache_refill.sv
// tb/tb_dcache_refill.sv - self-checking bench for dcache_refill with a reactive memory model
module tb_dcache_refill;

  localparam int ADDR_W = 64;
  localparam int LINE_W = 64;
  localparam int MEM_W  = 32;
  localparam int B      = LINE_W / MEM_W;
  localparam int STEP   = MEM_W / 8;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [MEM_W-1:0]  data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_miss, i_write_back;
  logic [ADDR_W-1:0] i_req_addr, i_victim_addr;
  logic [LINE_W-1:0] i_victim_data;
  logic              o_busy, o_refresh, o_fill_we;
  logic [LINE_W-1:0] o_fill_data;
  logic              o_mem_req, o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [MEM_W-1:0]  o_mem_wdata;
  logic              i_mem_ready, i_mem_rvalid;
  logic [MEM_W-1:0]  i_mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dcache_refill #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MEM_W(MEM_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_miss        (i_miss),
    .i_write_back  (i_write_back),
    .i_req_addr    (i_req_addr),
    .i_victim_addr (i_victim_addr),
    .i_victim_data (i_victim_data),
    .o_busy        (o_busy),
    .o_refresh     (o_refresh),
    .o_fill_we     (o_fill_we),
    .o_fill_data   (o_fill_data),
    .o_mem_req     (o_mem_req),
    .o_mem_we      (o_mem_we),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wdata   (o_mem_wdata),
    .i_mem_ready   (i_mem_ready),
    .i_mem_rvalid  (i_mem_rvalid),
    .i_mem_rdata   (i_mem_rdata)
  );

  // One full miss service against a memory that accepts each request after
  // rdy_wait cycles and returns read data rv_d cycles after acceptance.
  task automatic service(input string name, input bit dirty,
                         input logic [ADDR_W-1:0] raddr, input logic [ADDR_W-1:0] vaddr,
                         input logic [LINE_W-1:0] vdata, input logic [LINE_W-1:0] rline,
                         input int rdy_wait, input int rv_d, input bit rnd, input bit stray,
                         input bit hold_miss, output logic [LINE_W-1:0] fill_obs);
    beat_t exp_q[$];
    beat_t obs_q[$];
    beat_t h;
    logic [ADDR_W-1:0] base;
    int cyc, lat, exp_lat, rv_left, wait_left, rd_idx, n;
    bit req_active, saw;
    h = '0; fill_obs = '0; cyc = 0; lat = 0; rv_left = 0; wait_left = 0; rd_idx = 0;
    req_active = 0; saw = 0;
    base = {raddr[ADDR_W-1:3], 3'b000};
    if (dirty)
      for (int b = 0; b < B; b++)
        exp_q.push_back('{1'b1, vaddr + ADDR_W'(b * STEP), vdata[b*MEM_W +: MEM_W]});
    for (int b = 0; b < B; b++)
      exp_q.push_back('{1'b0, base + ADDR_W'(b * STEP), '0});
    exp_lat = 1 + (dirty ? B * (1 + rdy_wait) : 0) + B * (1 + rdy_wait + rv_d);

    i_miss = 1'b1; i_write_back = dirty; i_req_addr = raddr;
    i_victim_addr = vaddr; i_victim_data = vdata;
    while (!saw && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (o_refresh === 1'b1) begin
        saw = 1; lat = cyc; fill_obs = o_fill_data;
        tests++;
        if (o_fill_we !== 1'b1) begin
          fails++; $display("FAIL %s fill_we: got %b want 1", name, o_fill_we);
        end
      end
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = $urandom;
      if (rv_left > 0) begin
        rv_left--;
        if (rv_left == 0) begin
          i_mem_rvalid = 1'b1;
          if (rd_idx < B) i_mem_rdata = rline[rd_idx*MEM_W +: MEM_W];
          rd_idx++;
        end
      end else if (stray && $urandom_range(0, 2) == 0) begin
        i_mem_rvalid = 1'b1;
      end
      i_mem_ready = 1'b0;
      if (o_mem_req === 1'b1) begin
        if (!req_active) begin
          req_active = 1;
          h = '{o_mem_we, o_mem_addr, o_mem_wdata};
          wait_left = rnd ? int'($urandom_range(0, rdy_wait)) : rdy_wait;
        end else begin
          tests++;
          if ({o_mem_we, o_mem_addr, o_mem_wdata} !== h) begin
            fails++;
            $display("FAIL %s hold: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                     name, o_mem_we, o_mem_addr, o_mem_wdata, h.we, h.addr, h.data);
          end
        end
        if (wait_left == 0) begin
          i_mem_ready = 1'b1;
          req_active = 0;
          obs_q.push_back(h);
          if (!h.we) begin
            tests++;
            if (rv_left != 0) begin
              fails++; $display("FAIL %s outstanding: got second read want one at a time", name);
            end
            rv_left = rnd ? int'($urandom_range(1, rv_d)) : rv_d;
          end
        end else begin
          wait_left--;
        end
      end else if (stray) begin
        i_mem_ready = 1'($urandom_range(0, 1));
      end
      if (!saw) begin
        i_req_addr = {$urandom, $urandom}; i_victim_addr = {$urandom, $urandom};
        i_victim_data = {$urandom, $urandom}; i_write_back = 1'($urandom_range(0, 1));
        if (!hold_miss) i_miss = 1'($urandom_range(0, 1));
      end else if (!hold_miss) begin
        i_miss = 1'b0;
      end
    end
    if (!saw) begin
      tests++; fails++;
      $display("FAIL %s timeout: got no refresh within %0d cycles want one", name, cyc);
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL %s beat_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      tests++;
      if (obs_q[i].we !== exp_q[i].we || obs_q[i].addr !== exp_q[i].addr ||
          (exp_q[i].we && obs_q[i].data !== exp_q[i].data)) begin
        fails++;
        $display("FAIL %s beat%0d: got we=%b addr=%h data=%h want we=%b addr=%h data=%h", name, i,
                 obs_q[i].we, obs_q[i].addr, obs_q[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
      end
    end
    tests++;
    if (fill_obs !== rline) begin
      fails++; $display("FAIL %s fill_data: got %h want %h", name, fill_obs, rline);
    end
    if (!rnd) begin
      tests++;
      if (lat != exp_lat) begin
        fails++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
    end
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
    @(negedge clk);
    tests++;
    if (o_refresh !== 1'b0 || o_fill_we !== 1'b0 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL %s done_cycle: got refresh=%b fill_we=%b busy=%b want 0 0 0",
               name, o_refresh, o_fill_we, o_busy);
    end
    @(negedge clk);
    tests++;
    if (o_refresh !== 1'b0 || o_busy !== hold_miss) begin
      fails++;
      $display("FAIL %s idle_cycle: got refresh=%b busy=%b want 0 %b", name, o_refresh, o_busy, hold_miss);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_miss = 0; i_write_back = 0; i_req_addr = '0; i_victim_addr = '0;
    i_victim_data = '0; i_mem_ready = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({o_busy, o_refresh, o_fill_we, o_mem_req, o_mem_we} !== 5'b0) begin
        fails++; $display("FAIL reset_flags: got %b want 00000", {o_busy, o_refresh, o_fill_we, o_mem_req, o_mem_we});
      end
      tests++;
      if (o_mem_addr !== '0 || o_mem_wdata !== '0 || o_fill_data !== '0) begin
        fails++; $display("FAIL reset_data: got addr=%h wdata=%h fill=%h want 0", o_mem_addr, o_mem_wdata, o_fill_data);
      end
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_clean_miss();
    logic [LINE_W-1:0] f;
    service("clean", 0, 64'h0000_0000_8000_1234, '0, '0, 64'h22222222_11111111, 0, 1, 0, 0, 0, f);
    tests++;
    if (f !== 64'h22222222_11111111) begin
      fails++; $display("FAIL clean_line: got %h want 2222222211111111", f);
    end
  endtask

  task automatic test_dirty_miss();
    logic [LINE_W-1:0] f;
    service("dirty", 1, 64'h0000_0000_9000_0008, 64'h0000_0000_8000_0040, 64'hAAAA_BBBB_CCCC_DDDD,
            64'h44444444_33333333, 0, 1, 0, 0, 0, f);
  endtask

  task automatic test_backpressure();
    logic [LINE_W-1:0] f;
    service("bp_dirty", 1, {$urandom, $urandom}, {$urandom, $urandom} & ~64'h7,
            {$urandom, $urandom}, {$urandom, $urandom}, 5, 1, 0, 0, 0, f);
    service("bp_clean", 0, {$urandom, $urandom}, '0, '0, {$urandom, $urandom}, 5, 1, 0, 0, 0, f);
  endtask

  task automatic test_stray();
    logic [LINE_W-1:0] f;
    service("stray_clean", 0, {$urandom, $urandom}, '0, '0, {$urandom, $urandom}, 2, 3, 0, 1, 0, f);
    service("stray_dirty", 1, {$urandom, $urandom}, {$urandom, $urandom} & ~64'h7,
            {$urandom, $urandom}, {$urandom, $urandom}, 1, 2, 0, 1, 0, f);
  endtask

  task automatic test_reset_mid();
    i_miss = 1; i_write_back = 0; i_req_addr = 64'h0000_0000_1234_5678;
    @(negedge clk);
    tests++;
    if (o_mem_req !== 1'b1 || o_mem_we !== 1'b0) begin
      fails++; $display("FAIL rstmid_req: got req=%b we=%b want 1 0", o_mem_req, o_mem_we);
    end
    i_mem_ready = 1;
    @(negedge clk);
    tests++;
    if (o_mem_req !== 1'b0) begin
      fails++; $display("FAIL rstmid_wait: got req=%b want 0", o_mem_req);
    end
    i_mem_ready = 0; rst = 1; i_miss = 0;
    @(negedge clk);
    rst = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      tests++;
      if ({o_busy, o_refresh, o_fill_we, o_mem_req, o_mem_we} !== 5'b0 ||
          o_mem_addr !== '0 || o_mem_wdata !== '0 || o_fill_data !== '0) begin
        fails++;
        $display("FAIL rstmid_idle%0d: got flags=%b addr=%h wdata=%h fill=%h want all 0", k,
                 {o_busy, o_refresh, o_fill_we, o_mem_req, o_mem_we}, o_mem_addr, o_mem_wdata, o_fill_data);
      end
      @(negedge clk);
      i_mem_rvalid = 0;
    end
  endtask

  task automatic test_back_to_back();
    logic [LINE_W-1:0] f;
    service("b2b_0", 0, {$urandom, $urandom}, '0, '0, {$urandom, $urandom}, 0, 1, 0, 0, 1, f);
    service("b2b_1", 1, {$urandom, $urandom}, {$urandom, $urandom} & ~64'h7,
            {$urandom, $urandom}, {$urandom, $urandom}, 0, 1, 0, 0, 1, f);
    service("b2b_2", 0, {$urandom, $urandom}, '0, '0, {$urandom, $urandom}, 0, 1, 0, 0, 0, f);
  endtask

  task automatic test_random();
    logic [LINE_W-1:0] f;
    logic [ADDR_W-1:0] ra;
    for (int i = 0; i < 20; i++) begin
      ra = (i % 5 == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
      service("random", 1'($urandom_range(0, 1)), ra, {$urandom, $urandom} & ~64'h7,
              {$urandom, $urandom}, {$urandom, $urandom}, 4, 3, 1, 1'($urandom_range(0, 1)), 0, f);
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_backpressure();
    test_stray();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
